// File: rtl/huffman_pkg.sv
// Shared types for the Huffman lookup table: entry layout and FSM states.
package huffman_pkg;
    localparam int PATH_W  = 12;
    localparam int LEN_W   = 4;
    localparam int CHAR_W  = 8;
    localparam int MAX_LEN = 12;

    typedef struct packed {
        logic [CHAR_W-1:0] chr;
        logic [LEN_W-1:0]  len;
        logic [PATH_W-1:0] path;
    } entry_t;

    typedef enum logic {W_IDLE, W_ACK} w_state_e;
    typedef enum logic [1:0] {Q_IDLE, Q_SCAN, Q_RESP} q_state_e;
endpackage

// File: rtl/huffman_if.sv
// Write channel from the table builder and query channel from the decoder.
interface huffman_if;
    import huffman_pkg::*;

    logic              enable;
    logic [CHAR_W-1:0] lookupTab;
    logic [LEN_W-1:0]  length;
    logic [PATH_W-1:0] path;
    logic              saveComp;
    logic              query_req;
    logic [PATH_W-1:0] query_path;
    logic [LEN_W-1:0]  query_len;
    logic              query_done;
    logic              query_hit;
    logic [CHAR_W-1:0] query_char;

    modport master (
        output enable, lookupTab, length, path,
        output query_req, query_path, query_len,
        input  saveComp, query_done, query_hit, query_char
    );

    modport slave (
        input  enable, lookupTab, length, path,
        input  query_req, query_path, query_len,
        output saveComp, query_done, query_hit, query_char
    );
endinterface

// File: rtl/huffman_entry_match.sv
// Masked compare of one stored entry against the latched query.
module huffman_entry_match
    import huffman_pkg::*;
(
    input  entry_t            ent_i,
    input  logic [PATH_W-1:0] path_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              hit_o
);
    logic [PATH_W-1:0] mask;

    // A shift of 12 clears every bit, so the mask covers the full path.
    assign mask  = ~({PATH_W{1'b1}} << ent_i.len);
    assign hit_o = (ent_i.len == len_i) &&
                   (((ent_i.path ^ path_i) & mask) == '0);
endmodule

// File: rtl/huffman_table.sv
// Entry store filled by the builder, searched one entry per cycle by the decoder.
module huffman_table
    import huffman_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   decodeDone,
    huffman_if.slave               bus,
    output logic [$clog2(DEPTH):0] entry_count,
    output logic                   table_full,
    output logic                   len_error
);
    localparam int IDXW = $clog2(DEPTH);
    localparam int CNTW = IDXW + 1;

    entry_t            mem_q [DEPTH];
    w_state_e          w_state_q;
    logic              ack_q;
    logic [CNTW-1:0]   cnt_q;
    logic              full_q;
    logic              lerr_q;
    logic              len_ok;
    logic              wr_en;

    q_state_e          q_state_q;
    logic [PATH_W-1:0] qpath_q;
    logic [LEN_W-1:0]  qlen_q;
    logic [CNTW-1:0]   snap_q;
    logic [IDXW-1:0]   idx_q;
    logic              done_q;
    logic              hit_q;
    logic [CHAR_W-1:0] char_q;
    entry_t            cur;
    logic              m_hit;
    logic              empty;
    logic              last;

    assign len_ok = (bus.length != '0) &&
                    (bus.length <= LEN_W'(MAX_LEN));
    assign wr_en  = (w_state_q == W_IDLE) && bus.enable &&
                    len_ok && !full_q && !decodeDone;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[cnt_q[IDXW-1:0]] <= '{chr:  bus.lookupTab,
                                        len:  bus.length,
                                        path: bus.path};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            w_state_q <= W_IDLE;
            ack_q     <= 1'b0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            lerr_q    <= 1'b0;
        end else if (decodeDone) begin
            w_state_q <= W_IDLE;
            ack_q     <= 1'b0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            lerr_q    <= 1'b0;
        end else begin
            unique case (w_state_q)
                W_IDLE: begin
                    if (bus.enable) begin
                        w_state_q <= W_ACK;
                        ack_q     <= 1'b1;
                        if (!len_ok) begin
                            lerr_q <= 1'b1;
                        end else if (!full_q) begin
                            cnt_q  <= cnt_q + 1'b1;
                            full_q <= (cnt_q == CNTW'(DEPTH - 1));
                        end
                    end
                end
                W_ACK: begin
                    w_state_q <= W_IDLE;
                    ack_q     <= 1'b0;
                end
            endcase
        end
    end

    assign cur   = mem_q[idx_q];
    assign empty = (snap_q == '0);
    assign last  = ({1'b0, idx_q} == snap_q - 1'b1);

    huffman_entry_match u_match (
        .ent_i  (cur),
        .path_i (qpath_q),
        .len_i  (qlen_q),
        .hit_o  (m_hit)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q_state_q <= Q_IDLE;
            qpath_q   <= '0;
            qlen_q    <= '0;
            snap_q    <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            char_q    <= '0;
        end else if (decodeDone) begin
            q_state_q <= Q_IDLE;
            done_q    <= 1'b0;
        end else begin
            unique case (q_state_q)
                Q_IDLE: begin
                    if (bus.query_req) begin
                        qpath_q   <= bus.query_path;
                        qlen_q    <= bus.query_len;
                        snap_q    <= cnt_q;
                        idx_q     <= '0;
                        q_state_q <= Q_SCAN;
                    end
                end
                Q_SCAN: begin
                    // Stale slots beyond the snapshot are never compared.
                    if (!empty && m_hit) begin
                        q_state_q <= Q_RESP;
                        done_q    <= 1'b1;
                        hit_q     <= 1'b1;
                        char_q    <= cur.chr;
                    end else if (empty || last) begin
                        q_state_q <= Q_RESP;
                        done_q    <= 1'b1;
                        hit_q     <= 1'b0;
                        char_q    <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                Q_RESP: begin
                    q_state_q <= Q_IDLE;
                    done_q    <= 1'b0;
                end
                default: begin
                    q_state_q <= Q_IDLE;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.saveComp   = ack_q;
    assign bus.query_done = done_q;
    assign bus.query_hit  = hit_q;
    assign bus.query_char = char_q;
    assign entry_count    = cnt_q;
    assign table_full     = full_q;
    assign len_error      = lerr_q;
endmodule

// File: tb/tb_huffman_table.sv
// Directed bench for huffman_table: writes, searches, full/illegal, clear, reset.
module tb_huffman_table;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       decodeDone = 1'b0;
    logic [3:0] entry_count;
    logic       table_full;
    logic       len_error;
    int         tests = 0;
    int         fails = 0;

    huffman_if bus();

    huffman_table #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .decodeDone  (decodeDone),
        .bus         (bus),
        .entry_count (entry_count),
        .table_full  (table_full),
        .len_error   (len_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] c, input logic [3:0] l,
                      input logic [11:0] p);
        int n = 0;
        bus.enable    = 1'b1;
        bus.lookupTab = c;
        bus.length    = l;
        bus.path      = p;
        do begin
            tick();
            n++;
        end while (!bus.saveComp && n < 5);
        chk("ack_lat", n, 1);
        // Builder still holds enable through the ack cycle.
        tick();
        chk("ack_once", {31'b0, bus.saveComp}, 0);
        bus.enable = 1'b0;
    endtask

    task automatic qry(input logic [11:0] p, input logic [3:0] l,
                       input logic h, input logic [7:0] c, input int cyc);
        int n = 0;
        bus.query_req  = 1'b1;
        bus.query_path = p;
        bus.query_len  = l;
        tick();
        n = 1;
        bus.query_req = 1'b0;
        while (!bus.query_done && n < 40) begin
            tick();
            n++;
        end
        chk("q_lat", n, cyc);
        chk("q_hit", {31'b0, bus.query_hit}, {31'b0, h});
        chk("q_char", {24'b0, bus.query_char}, {24'b0, c});
        tick();
        chk("q_once", {31'b0, bus.query_done}, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"}, {31'b0, bus.saveComp}, 0);
        chk({tag, "_done"}, {31'b0, bus.query_done}, 0);
        chk({tag, "_hit"}, {31'b0, bus.query_hit}, 0);
        chk({tag, "_char"}, {24'b0, bus.query_char}, 0);
        chk({tag, "_cnt"}, {28'b0, entry_count}, 0);
        chk({tag, "_full"}, {31'b0, table_full}, 0);
        chk({tag, "_lerr"}, {31'b0, len_error}, 0);
    endtask

    initial begin
        int seen;
        bus.enable     = 1'b0;
        bus.lookupTab  = '0;
        bus.length     = '0;
        bus.path       = '0;
        bus.query_req  = 1'b0;
        bus.query_path = '0;
        bus.query_len  = '0;

        #2;
        chk_zero("rst");
        tick();
        n_rst = 1'b1;
        tick();

        qry(12'h005, 4'd3, 1'b0, 8'h00, 2);

        wr(8'h41, 4'd3, 12'h005);
        chk("cnt1", {28'b0, entry_count}, 1);
        wr(8'h42, 4'd2, 12'h001);
        wr(8'h43, 4'd4, 12'h00C);
        chk("cnt3", {28'b0, entry_count}, 3);

        qry(12'hF0C, 4'd4, 1'b1, 8'h43, 4);
        qry(12'h002, 4'd2, 1'b0, 8'h00, 4);
        qry(12'hAA5, 4'd3, 1'b1, 8'h41, 2);

        wr(8'h99, 4'd13, 12'h001);
        chk("lerr13", {31'b0, len_error}, 1);
        chk("cnt_il", {28'b0, entry_count}, 3);
        wr(8'h98, 4'd0, 12'h000);
        chk("cnt_il0", {28'b0, entry_count}, 3);

        bus.query_req  = 1'b1;
        bus.query_path = 12'h002;
        bus.query_len  = 4'd2;
        tick();
        bus.query_req = 1'b0;
        decodeDone    = 1'b1;
        tick();
        decodeDone = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.query_done) seen++;
            tick();
        end
        chk("clr_nodone", seen, 0);
        chk("clr_cnt", {28'b0, entry_count}, 0);
        chk("clr_lerr", {31'b0, len_error}, 0);
        qry(12'h005, 4'd3, 1'b0, 8'h00, 2);

        for (int i = 0; i < DEPTH + 1; i++) begin
            wr(8'h50 + 8'(i), 4'd5, 12'(i));
        end
        chk("full_cnt", {28'b0, entry_count}, DEPTH);
        chk("full_flag", {31'b0, table_full}, 1);
        qry(12'h007, 4'd5, 1'b1, 8'h57, 9);
        qry(12'h01F, 4'd5, 1'b0, 8'h00, 9);

        bus.query_req  = 1'b1;
        bus.query_path = 12'h01F;
        bus.query_len  = 4'd5;
        tick();
        bus.query_req = 1'b0;
        tick();
        tick();
        n_rst = 1'b0;
        #1;
        chk_zero("rst_scan");
        #3;
        n_rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.query_done) seen++;
        end
        chk("rst_nodone", seen, 0);

        wr(8'h61, 4'd1, 12'h001);
        bus.enable    = 1'b1;
        bus.lookupTab = 8'h62;
        bus.length    = 4'd2;
        bus.path      = 12'h002;
        tick();
        chk("wack_pre", {31'b0, bus.saveComp}, 1);
        n_rst = 1'b0;
        #1;
        chk_zero("rst_wack");
        bus.enable = 1'b0;
        #3;
        n_rst = 1'b1;
        tick();
        chk("wack_post", {31'b0, bus.saveComp}, 0);
        qry(12'h001, 4'd1, 1'b0, 8'h00, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/huffman_table.md
# huffman_table

Storage and search stage directly downstream of the lookup-table builder in the Huffman decompressor. Accepts one (character, code length, code path) entry per `enable` handshake from the builder and answers with a one-cycle `saveComp` pulse. Serves the decode block with a sequential search: given a candidate path and length, it scans stored entries one per cycle and returns the matching character or a miss. Cleared on `decodeDone` so the next file starts with an empty table.

## Interface
Parameters:
- DEPTH, 32: maximum stored entries; power of two, 2..256.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- enable  in  1  write request from builder; held high until `saveComp` is seen.
- lookupTab  in  8  character to store.
- length  in  4  code length in bits; legal values 1..12.
- path  in  12  code bits; `path[0]` is the first bit, only `path[length-1:0]` is significant.
- saveComp  out  1  one-cycle write acknowledge.
- decodeDone  in  1  clear table; has priority over everything.
- query_req  in  1  search request from decode block, one-cycle pulse.
- query_path  in  12  candidate path; sampled with `query_req`.
- query_len  in  4  candidate length; sampled with `query_req`.
- query_done  out  1  one-cycle pulse: result valid.
- query_hit  out  1  match found; valid with `query_done`.
- query_char  out  8  matched character; 0 on miss.
- entry_count  out  log2(DEPTH)+1  number of stored entries.
- table_full  out  1  `entry_count == DEPTH`.
- len_error  out  1  sticky: a write with length 0 or >12 was rejected.

## Operation
- Write FSM, states W_IDLE, W_ACK:
  - W_IDLE with `enable=1`: go to W_ACK.
    - If the length is legal and the table is not full: store the entry at index `entry_count` and increment the count.
    - If the table is full: drop the data.
    - If the length is illegal: drop the data and set `len_error`.
  - W_ACK: `saveComp=1` for that cycle, `enable` is ignored, and the FSM returns to W_IDLE. This guarantees one write per handshake even though the builder holds `enable` through the ack cycle.
  - An ack is always issued, even on a drop, so the builder never hangs.
- Search FSM, states Q_IDLE, Q_SCAN, Q_RESP:
  - Q_IDLE with `query_req`: latch path, length and a snapshot of `entry_count`; set idx=0; go to Q_SCAN.
  - Q_SCAN, hit test: entry[idx] is a hit when `len == query_len` and `path[len-1:0] == query_path[len-1:0]`.
  - Q_SCAN, hit: go to Q_RESP with hit=1, char=entry.char.
  - Q_SCAN, miss at the last index, or snapshot count 0: go to Q_RESP with a miss.
  - Q_SCAN, miss otherwise: idx+1.
  - Q_RESP: `query_done=1` for one cycle, then Q_IDLE.
  - The first matching index wins; duplicate entries are not detected.
- `query_req` outside Q_IDLE is ignored; the decode block must wait for `query_done`.
- The write and search FSMs run independently. An entry written on edge N is visible to a scan compare from cycle N+1, but only if its index is below the snapshot count.
- `decodeDone=1` on a rising edge:
  - `entry_count`→0, `len_error`→0, both FSMs→idle.
  - Any in-flight query is aborted with no `query_done`, and any pending write is aborted with no `saveComp`.
  - Entry contents need not be cleared.

## Timing
- Reset values: `saveComp`=0, `query_done`=0, `query_hit`=0, `query_char`=0, `entry_count`=0, `table_full`=0, `len_error`=0; FSMs in W_IDLE/Q_IDLE.
- All outputs are registered.
- Write latency:
  - `enable` first high in cycle k → `saveComp` high in cycle k+1 only.
  - `entry_count` updates in cycle k+1.
- Query latency, with `query_req` in cycle 0:
  - Hit at index i: `query_done` in cycle i+2.
  - Miss: `query_done` in cycle max(count,1)+1.
- `query_hit`/`query_char` hold their values until the next `query_done`.
- A write into the full table: count stays at DEPTH, `table_full` stays 1, ack still issued.
- Index arithmetic is unsigned log2(DEPTH) bits; the count is one bit wider so that DEPTH is representable.

## Structure
- Shared package `huffman_pkg`:
  - `PATH_W=12`, `LEN_W=4`, `CHAR_W=8`, `MAX_LEN=12`.
  - Entry struct {char, len, path}.
  - Write and search state enums.
- One sub-module, `huffman_entry_match`: combinational masked compare of one entry against the latched query, producing hit.
- Storage is a flip-flop array of entry structs.

## Test plan
- Reset mid-operation: assert `n_rst` low during a Q_SCAN and during W_ACK → all outputs 0 immediately, both FSMs idle.
- Single write: `enable` held with char 0x41, len 3, path 0b101 → `saveComp` one cycle later, exactly one pulse; `entry_count`=1 even though `enable` is still high in the ack cycle.
- Query hit at depth: write entries 0x41/3/0b101, 0x42/2/0b01, 0x43/4/0b1100; query len 4 path 0x00C (upper bits nonzero garbage allowed) → `query_done` 4 cycles after req, hit=1, char=0x43.
- Miss and empty:
  - Empty table: query → `query_done` in cycle 2, hit=0, char=0.
  - 3 entries, query len 2 path 0b10 → miss at cycle 4.
- Full and illegal writes:
  - DEPTH+1 writes → count=DEPTH, `table_full`=1, every write acked.
  - Write with len 13 → ack, `len_error`=1, count unchanged.
- Clear: `decodeDone` pulse during an active scan → no `query_done`, count=0, `len_error`=0; a subsequent query misses.
